fifo_xfer_sched: RTL and testbench

FIFO_XFER_SCHED -- requirements
Module: fifo_xfer_sched

---
 rtl/fifo_xfer_sched.sv | 145 ++++++++++++++
 tb/tb_fifo_xfer_sched.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_xfer_sched.sv
// SCSI/host FIFO transfer scheduler with registered strobes.
// Define FIFO_RR_ARB_EN for round-robin tie-break; default: SCSI wins ties.
module fifo_xfer_sched (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  input  logic DIR,
  input  logic SREQ,
  input  logic DREQ,
  input  logic FLUSH,
  input  logic FIFOFULL,
  input  logic FIFOEMPTY,
  input  logic BOEQ0,
  input  logic BOEQ3,
  output logic LBYTE_,
  output logic INCBO,
  output logic INCNI,
  output logic INCNO,
  output logic INCFIFO,
  output logic DECFIFO,
  output logic LLWORD,
  output logic LHWORD,
  output logic SACK,
  output logic DACK,
  output logic FLUSHDONE,
  output logic BUSY
);

  typedef enum logic [2:0] {
    IDLE, SBYTE, DRD, DWLO, DWHI, FLSH
  } state_t;

  state_t r_state;
  logic   r_lbyte_n;
  logic   r_incbo;
  logic   r_incni;
  logic   r_incno;
  logic   r_incfifo;
  logic   r_decfifo;
  logic   r_llword;
  logic   r_lhword;
  logic   r_sack;
  logic   r_dack;
  logic   r_flushdone;

  logic w_s_elig;
  logic w_h_elig;
  logic w_s_win;

  assign w_s_elig = EN && SREQ && (DIR ? !FIFOFULL : !FIFOEMPTY);
  assign w_h_elig = EN && DREQ && (DIR ? !FIFOEMPTY : !FIFOFULL);

`ifdef FIFO_RR_ARB_EN
  logic r_last_host;
  assign w_s_win = w_s_elig && (!w_h_elig || r_last_host);
`else
  assign w_s_win = w_s_elig;
`endif

  // Strobes are computed one edge ahead so they align with the state.
  always_ff @(posedge CLK) begin
    r_lbyte_n   <= 1'b1;
    r_incbo     <= 1'b0;
    r_incni     <= 1'b0;
    r_incno     <= 1'b0;
    r_incfifo   <= 1'b0;
    r_decfifo   <= 1'b0;
    r_llword    <= 1'b0;
    r_lhword    <= 1'b0;
    r_sack      <= 1'b0;
    r_dack      <= 1'b0;
    r_flushdone <= 1'b0;
    if (RST) begin
      r_state <= IDLE;
`ifdef FIFO_RR_ARB_EN
      r_last_host <= 1'b1;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (EN && DIR && FLUSH) begin
            r_flushdone <= 1'b1;
            if (!BOEQ0) begin
              r_state   <= FLSH;
              r_incni   <= 1'b1;
              r_incfifo <= 1'b1;
            end
          end else if (w_s_win) begin
            r_state   <= SBYTE;
            r_incbo   <= 1'b1;
            r_sack    <= 1'b1;
            r_lbyte_n <= !DIR;
            if (BOEQ3) begin
              r_incni   <= DIR;
              r_incfifo <= DIR;
              r_incno   <= !DIR;
              r_decfifo <= !DIR;
            end
`ifdef FIFO_RR_ARB_EN
            r_last_host <= 1'b0;
`endif
          end else if (w_h_elig) begin
            if (DIR) begin
              r_state   <= DRD;
              r_incno   <= 1'b1;
              r_decfifo <= 1'b1;
              r_dack    <= 1'b1;
`ifdef FIFO_RR_ARB_EN
              r_last_host <= 1'b1;
`endif
            end else begin
              r_state  <= DWLO;
              r_llword <= 1'b1;
            end
          end
        end
        DWLO: begin
          r_state   <= DWHI;
          r_lhword  <= 1'b1;
          r_incni   <= 1'b1;
          r_incfifo <= 1'b1;
          r_dack    <= 1'b1;
`ifdef FIFO_RR_ARB_EN
          r_last_host <= 1'b1;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign LBYTE_    = r_lbyte_n;
  assign INCBO     = r_incbo;
  assign INCNI     = r_incni;
  assign INCNO     = r_incno;
  assign INCFIFO   = r_incfifo;
  assign DECFIFO   = r_decfifo;
  assign LLWORD    = r_llword;
  assign LHWORD    = r_lhword;
  assign SACK      = r_sack;
  assign DACK      = r_dack;
  assign FLUSHDONE = r_flushdone;
  assign BUSY      = (r_state != IDLE);

endmodule

// File: tb/tb_fifo_xfer_sched.sv
// Bench for fifo_xfer_sched: directed scenarios plus randomized run
// against a queue-based transaction model.
module tb_fifo_xfer_sched;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic EN = 1'b0, DIR = 1'b0, SREQ = 1'b0, DREQ = 1'b0, FLUSH = 1'b0;
  logic FIFOFULL = 1'b0, FIFOEMPTY = 1'b1, BOEQ0 = 1'b1, BOEQ3 = 1'b0;
  logic LBYTE_, INCBO, INCNI, INCNO, INCFIFO, DECFIFO;
  logic LLWORD, LHWORD, SACK, DACK, FLUSHDONE, BUSY;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  fifo_xfer_sched dut (
    .CLK(CLK), .RST(RST), .EN(EN), .DIR(DIR), .SREQ(SREQ), .DREQ(DREQ),
    .FLUSH(FLUSH), .FIFOFULL(FIFOFULL), .FIFOEMPTY(FIFOEMPTY),
    .BOEQ0(BOEQ0), .BOEQ3(BOEQ3), .LBYTE_(LBYTE_), .INCBO(INCBO),
    .INCNI(INCNI), .INCNO(INCNO), .INCFIFO(INCFIFO), .DECFIFO(DECFIFO),
    .LLWORD(LLWORD), .LHWORD(LHWORD), .SACK(SACK), .DACK(DACK),
    .FLUSHDONE(FLUSHDONE), .BUSY(BUSY)
  );

  logic [11:0] dut_v;
  assign dut_v = {LBYTE_, INCBO, INCNI, INCNO, INCFIFO, DECFIFO,
                  LLWORD, LHWORD, SACK, DACK, FLUSHDONE, BUSY};

  localparam logic [11:0] V_LBN  = 12'h800;
  localparam logic [11:0] V_BO   = 12'h400;
  localparam logic [11:0] V_NI   = 12'h200;
  localparam logic [11:0] V_NO   = 12'h100;
  localparam logic [11:0] V_IF   = 12'h080;
  localparam logic [11:0] V_DF   = 12'h040;
  localparam logic [11:0] V_LLW  = 12'h020;
  localparam logic [11:0] V_LHW  = 12'h010;
  localparam logic [11:0] V_SACK = 12'h008;
  localparam logic [11:0] V_DACK = 12'h004;
  localparam logic [11:0] V_FD   = 12'h002;
  localparam logic [11:0] V_BUSY = 12'h001;
  localparam logic [11:0] V_IDLE = V_LBN;

`ifdef FIFO_RR_ARB_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // Model: when nothing is queued the scheduler is idle and picks a
  // transfer, queueing the whole output sequence that transfer produces.
  logic [11:0] q[$];
  logic [11:0] exp_v = V_IDLE;
  bit last_host = 1'b1;
  bit pend_last = 1'b0;

  task automatic model_edge();
    bit s_ok, h_ok, pick_s;
    if (RST) begin
      q.delete();
      pend_last = 0;
      last_host = 1;
      exp_v = V_IDLE;
    end else if (q.size() > 0) begin
      exp_v = q.pop_front();
      if (pend_last && (exp_v & V_LHW) != 0) begin
        last_host = 1;
        pend_last = 0;
      end
    end else if (EN && DIR && FLUSH) begin
      if (!BOEQ0) begin
        exp_v = V_IDLE | V_BUSY | V_NI | V_IF | V_FD;
        q.push_back(V_IDLE);
      end else begin
        exp_v = V_IDLE | V_FD;
      end
    end else begin
      s_ok = EN && SREQ && (DIR ? !FIFOFULL : !FIFOEMPTY);
      h_ok = EN && DREQ && (DIR ? !FIFOEMPTY : !FIFOFULL);
      pick_s = s_ok && (!h_ok || !RR || last_host);
      if (pick_s) begin
        exp_v = V_BUSY | V_BO | V_SACK | (DIR ? 12'h000 : V_LBN);
        if (BOEQ3) exp_v |= DIR ? (V_NI | V_IF) : (V_NO | V_DF);
        q.push_back(V_IDLE);
        last_host = 0;
      end else if (h_ok && DIR) begin
        exp_v = V_IDLE | V_BUSY | V_NO | V_DF | V_DACK;
        q.push_back(V_IDLE);
        last_host = 1;
      end else if (h_ok) begin
        exp_v = V_IDLE | V_BUSY | V_LLW;
        q.push_back(V_IDLE | V_BUSY | V_LHW | V_NI | V_IF | V_DACK);
        q.push_back(V_IDLE);
        pend_last = 1;
      end else begin
        exp_v = V_IDLE;
      end
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic set_idle_inputs();
    EN = 1; DIR = 1; SREQ = 0; DREQ = 0; FLUSH = 0;
    FIFOFULL = 0; FIFOEMPTY = 1; BOEQ0 = 1; BOEQ3 = 0;
  endtask

  task automatic do_reset();
    RST = 1;
    step();
    step();
    RST = 0;
  endtask

  task automatic test_reset();
    set_idle_inputs();
    SREQ = 1; DREQ = 1; FLUSH = 1; BOEQ0 = 0;
    RST = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (dut_v !== 12'h800) begin
        failures++;
        $display("FAIL reset_outputs got=%h want=%h", dut_v, 12'h800);
      end
    end
    set_idle_inputs();
    RST = 0;
    step();
    checks++;
    if (BUSY !== 1'b0 || dut_v !== exp_v) begin
      failures++;
      $display("FAIL reset_first_idle got=%h want=%h", dut_v, exp_v);
    end
  endtask

  task automatic test_scsi_bytes();
    int nsack = 0, nlb = 0, nni = 0, ni_on4 = 0;
    int last_t = -1, gap_bad = 0;
    do_reset();
    set_idle_inputs();
    SREQ = 1;
    for (int t = 0; t < 8; t++) begin
      BOEQ3 = (nsack == 3);
      step();
      checks++;
      if (dut_v !== exp_v) begin
        failures++;
        $display("FAIL scsi_model t=%0d got=%h want=%h", t, dut_v, exp_v);
      end
      if (SACK) begin
        nsack++;
        if (last_t >= 0 && t - last_t != 2) gap_bad++;
        last_t = t;
        if (!LBYTE_) nlb++;
        if (INCNI && INCFIFO && nsack == 4) ni_on4 = 1;
      end
      if (INCNI) nni++;
    end
    SREQ = 0;
    step();
    step();
    checks++;
    if (nsack != 4 || nlb != 4 || gap_bad != 0) begin
      failures++;
      $display("FAIL scsi_bytes sack=%0d lbyte=%0d gapbad=%0d want 4/4/0",
               nsack, nlb, gap_bad);
    end
    checks++;
    if (nni != 1 || ni_on4 != 1) begin
      failures++;
      $display("FAIL scsi_wrap incni=%0d on4th=%0d want 1/1", nni, ni_on4);
    end
  endtask

  task automatic test_host_write();
    int nbusy = 0;
    logic [11:0] seen[4];
    set_idle_inputs();
    DIR = 0;
    DREQ = 1;
    FIFOEMPTY = 0;
    for (int t = 0; t < 4; t++) begin
      step();
      DREQ = 0;
      seen[t] = dut_v;
      if (BUSY) nbusy++;
      checks++;
      if (dut_v !== exp_v) begin
        failures++;
        $display("FAIL hostw_model t=%0d got=%h want=%h", t, dut_v, exp_v);
      end
    end
    checks++;
    if (seen[0] !== (V_IDLE | V_BUSY | V_LLW) ||
        seen[1] !== (V_IDLE | V_BUSY | V_LHW | V_NI | V_IF | V_DACK) ||
        seen[2] !== V_IDLE || nbusy != 2) begin
      failures++;
      $display("FAIL host_write got=%h,%h,%h busy=%0d want=%h,%h,%h busy=2",
               seen[0], seen[1], seen[2], nbusy, V_IDLE | V_BUSY | V_LLW,
               V_IDLE | V_BUSY | V_LHW | V_NI | V_IF | V_DACK, V_IDLE);
    end
  endtask

  task automatic test_arbitration();
    string got = "";
    string want;
    do_reset();
    set_idle_inputs();
    FIFOEMPTY = 0;
    SREQ = 1;
    DREQ = 1;
    for (int t = 0; t < 8; t++) begin
      step();
      checks++;
      if (dut_v !== exp_v) begin
        failures++;
        $display("FAIL arb_model t=%0d got=%h want=%h", t, dut_v, exp_v);
      end
      if (SACK) got = {got, "S"};
      if (DACK) got = {got, "H"};
    end
    SREQ = 0;
    DREQ = 0;
    step();
    want = RR ? "SHSH" : "SSSS";
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL arbitration got=%s want=%s", got, want);
    end
  endtask

  task automatic test_flush();
    set_idle_inputs();
    step();
    SREQ = 1;
    FLUSH = 1;
    BOEQ0 = 0;
    step();
    FLUSH = 0;
    SREQ = 0;
    checks++;
    if (dut_v !== (V_IDLE | V_BUSY | V_NI | V_IF | V_FD)) begin
      failures++;
      $display("FAIL flush_partial got=%h want=%h", dut_v,
               V_IDLE | V_BUSY | V_NI | V_IF | V_FD);
    end
    step();
    step();
    FLUSH = 1;
    BOEQ0 = 1;
    SREQ = 1;
    step();
    FLUSH = 0;
    SREQ = 0;
    checks++;
    if (dut_v !== (V_IDLE | V_FD)) begin
      failures++;
      $display("FAIL flush_aligned got=%h want=%h", dut_v, V_IDLE | V_FD);
    end
    step();
    step();
    DIR = 0;
    FLUSH = 1;
    BOEQ0 = 0;
    step();
    FLUSH = 0;
    checks++;
    if (FLUSHDONE !== 1'b0 || dut_v !== exp_v) begin
      failures++;
      $display("FAIL flush_dir0 got=%h want=%h", dut_v, exp_v);
    end
    step();
  endtask

  task automatic test_blocked();
    int nsack = 0, ndack = 0;
    set_idle_inputs();
    FIFOFULL = 1;
    FIFOEMPTY = 0;
    SREQ = 1;
    for (int t = 0; t < 4; t++) begin
      step();
      if (SACK) nsack++;
    end
    FIFOFULL = 0;
    FIFOEMPTY = 1;
    SREQ = 0;
    DREQ = 1;
    for (int t = 0; t < 4; t++) begin
      step();
      if (DACK) ndack++;
    end
    DREQ = 0;
    checks++;
    if (nsack != 0 || ndack != 0) begin
      failures++;
      $display("FAIL blocked sack=%0d dack=%0d want 0/0", nsack, ndack);
    end
  endtask

  task automatic test_reset_dwlo();
    set_idle_inputs();
    DIR = 0;
    FIFOEMPTY = 0;
    DREQ = 1;
    step();
    DREQ = 0;
    checks++;
    if (LLWORD !== 1'b1 || BUSY !== 1'b1) begin
      failures++;
      $display("FAIL dwlo_entry llword=%b busy=%b want 1/1", LLWORD, BUSY);
    end
    RST = 1;
    step();
    RST = 0;
    checks++;
    if (LHWORD !== 1'b0 || INCNI !== 1'b0 || DACK !== 1'b0 ||
        LBYTE_ !== 1'b1 || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL reset_dwlo got=%h want=%h", dut_v, V_IDLE);
    end
    step();
    checks++;
    if (dut_v !== V_IDLE) begin
      failures++;
      $display("FAIL reset_dwlo_after got=%h want=%h", dut_v, V_IDLE);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      RST = ($urandom_range(0, 59) == 0);
      EN = ($urandom_range(0, 7) != 0);
      DIR = ($urandom_range(0, 15) == 0) ? ~DIR : DIR;
      SREQ = $urandom_range(0, 1);
      DREQ = $urandom_range(0, 1);
      FLUSH = ($urandom_range(0, 9) == 0);
      FIFOFULL = ($urandom_range(0, 3) == 0);
      FIFOEMPTY = FIFOFULL ? 1'b0 : ($urandom_range(0, 3) == 0);
      BOEQ0 = $urandom_range(0, 1);
      BOEQ3 = $urandom_range(0, 1);
      step();
      checks++;
      if (dut_v !== exp_v) begin
        failures++;
        $display("FAIL random t=%0d got=%h want=%h", t, dut_v, exp_v);
      end
    end
    RST = 0;
  endtask

  initial begin
    test_reset();
    test_scsi_bytes();
    test_host_write();
    test_arbitration();
    test_flush();
    test_blocked();
    test_reset_dwlo();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
